// File: rtl/stream_mux_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr_pkg
// Description : Shared definitions for the N-to-1 packet stream multiplexer.
//               Arbitration mode codes, the FSM state type and a helper that
//               sizes channel-index fields.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_mux_rr_pkg;

    localparam int MODE_RR   = 0;   // round-robin arbitration
    localparam int MODE_PRIO = 1;   // fixed priority, lowest index wins

    typedef enum logic [0:0] {
        IDLE = 1'b0,                // free to arbitrate on every beat
        LOCK = 1'b1                 // grant held until the packet's last beat
    } state_t;

    // Width of a channel index; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr_arbiter
// Description : Purely combinational N-way arbiter. In round-robin mode the
//               search starts at ptr and wraps from NCH-1 to 0; in priority
//               mode the search always starts at channel 0.
// Ports       : req     [NCH]   request vector
//               ptr     [SELW]  round-robin start channel
//               gnt     [NCH]   one-hot grant (zero when no request)
//               gnt_idx [SELW]  binary index of the granted channel
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mux_rr_arbiter
    import stream_mux_rr_pkg::*;
#(
    parameter  int NCH  = 4,
    parameter  int MODE = MODE_RR,
    localparam int SELW = sel_width(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  gnt,
    output logic [SELW-1:0] gnt_idx
);

    logic [SELW-1:0] w_start;
    logic [SELW:0]   w_sum;     // one spare bit so start+offset cannot overflow
    logic [SELW-1:0] w_cand;
    logic            w_found;

    always_comb begin
        w_start = (MODE == MODE_PRIO) ? '0 : ptr;
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 0; k < NCH; k++) begin
            w_sum = {1'b0, w_start} + (SELW+1)'(k);
            if (w_sum >= (SELW+1)'(NCH)) begin
                w_sum = w_sum - (SELW+1)'(NCH);
            end
            w_cand = w_sum[SELW-1:0];
            if (!w_found && req[w_cand]) begin
                w_found      = 1'b1;
                gnt[w_cand]  = 1'b1;
                gnt_idx      = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr
// Description : N-to-1 valid/ready packet multiplexer with registered output.
//               A grant is held for a whole packet (until s_last). Arbitration
//               is round-robin (MODE=0) or fixed priority (MODE=1).
// Ports       : sys_clk    clock, rising edge
//               sys_rst_n  asynchronous active-low reset
//               s_valid    [NCH]     per-channel beat valid
//               s_ready    [NCH]     per-channel accept, one-hot or zero
//               s_data     [NCH*DW]  channel i at [i*DW +: DW]
//               s_last     [NCH]     per-channel end of packet
//               m_valid/m_data/m_last/m_chan  registered output beat
//               m_ready    sink accept
//               busy       high while a packet grant is locked
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter  int NCH  = 4,
    parameter  int DW   = 8,
    parameter  int MODE = MODE_RR,
    localparam int SELW = sel_width(NCH)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [NCH-1:0]    s_valid,
    output logic [NCH-1:0]    s_ready,
    input  logic [NCH*DW-1:0] s_data,
    input  logic [NCH-1:0]    s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DW-1:0]     m_data,
    output logic              m_last,
    output logic [SELW-1:0]   m_chan,
    output logic              busy
);

    state_t          r_state;
    logic [SELW-1:0] r_ptr;
    logic [SELW-1:0] r_lock_idx;
    logic            r_m_valid;
    logic [DW-1:0]   r_m_data;
    logic            r_m_last;
    logic [SELW-1:0] r_m_chan;

    logic [NCH-1:0]  w_arb_gnt;
    logic [SELW-1:0] w_arb_idx;
    logic [NCH-1:0]  w_gnt;
    logic [SELW-1:0] w_sel;
    logic            w_open;
    logic            w_accept;
    logic [SELW-1:0] w_ptr_nxt;

    stream_mux_rr_arbiter #(
        .NCH  (NCH),
        .MODE (MODE)
    ) u_arb (
        .req     (s_valid),
        .ptr     (r_ptr),
        .gnt     (w_arb_gnt),
        .gnt_idx (w_arb_idx)
    );

    always_comb begin
        // The output register can take a beat when empty or being drained.
        w_open = !r_m_valid || m_ready;
        if (r_state == LOCK) begin
            // Grant stays on the locked channel even while it has no valid.
            w_gnt = NCH'(1) << r_lock_idx;
            w_sel = r_lock_idx;
        end else begin
            w_gnt = w_arb_gnt;
            w_sel = w_arb_idx;
        end
        w_accept  = (|w_gnt) && w_open && s_valid[w_sel] && sys_rst_n;
        w_ptr_nxt = (w_sel == SELW'(NCH-1)) ? '0 : w_sel + SELW'(1);
    end

    // Gating with the reset keeps every ready low while reset is applied.
    assign s_ready = w_gnt & {NCH{w_open & sys_rst_n}};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_lock_idx <= '0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_m_last   <= 1'b0;
            r_m_chan   <= '0;
        end else begin
            if (w_accept) begin
                r_m_valid <= 1'b1;
                r_m_data  <= s_data[w_sel*DW +: DW];
                r_m_last  <= s_last[w_sel];
                r_m_chan  <= w_sel;
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (s_last[w_sel]) begin
                            if (MODE == MODE_RR) begin
                                r_ptr <= w_ptr_nxt;
                            end
                        end else begin
                            r_state    <= LOCK;
                            r_lock_idx <= w_sel;
                        end
                    end
                end
                LOCK: begin
                    if (w_accept && s_last[w_sel]) begin
                        r_state <= IDLE;
                        if (MODE == MODE_RR) begin
                            r_ptr <= w_ptr_nxt;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_last  = r_m_last;
    assign m_chan  = r_m_chan;
    assign busy    = (r_state == LOCK);

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_mux_rr
// Description : Bench for stream_mux_rr. A round-robin and a fixed-priority
//               instance share one set of randomized producers and are each
//               compared every cycle against a behavioural reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;
    import stream_mux_rr_pkg::*;

    localparam int NCH  = 4;
    localparam int DW   = 8;
    localparam int SELW = 2;

    logic              clk;
    logic              rst_n;
    logic [NCH-1:0]    s_valid;
    logic [NCH-1:0]    s_last;
    logic [NCH*DW-1:0] s_data;
    logic              m_ready;

    logic [NCH-1:0]    rdy [2];
    logic              mv  [2];
    logic [DW-1:0]     md  [2];
    logic              ml  [2];
    logic [SELW-1:0]   mc  [2];
    logic              bz  [2];

    stream_mux_rr #(.NCH(NCH), .DW(DW), .MODE(MODE_RR)) u_rr (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .s_valid(s_valid), .s_ready(rdy[0]), .s_data(s_data), .s_last(s_last),
        .m_valid(mv[0]), .m_ready(m_ready), .m_data(md[0]), .m_last(ml[0]),
        .m_chan(mc[0]), .busy(bz[0])
    );

    stream_mux_rr #(.NCH(NCH), .DW(DW), .MODE(MODE_PRIO)) u_prio (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .s_valid(s_valid), .s_ready(rdy[1]), .s_data(s_data), .s_last(s_last),
        .m_valid(mv[1]), .m_ready(m_ready), .m_data(md[1]), .m_last(ml[1]),
        .m_chan(mc[1]), .busy(bz[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state, one entry per instance (0 = round-robin, 1 = priority)
    bit            e_mv  [2];
    logic [DW-1:0] e_md  [2];
    bit            e_ml  [2];
    int            e_mc  [2];
    bit            e_lk  [2];
    int            e_lch [2];
    int            e_ptr [2];

    // Producers: packets of counting data, advanced on round-robin accepts
    bit             pv   [NCH];
    logic [DW-1:0]  pdat [NCH];
    int             prem [NCH];
    logic [NCH-1:0] acc0;

    int n_vec;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            e_mv[d] = 0; e_md[d] = '0; e_ml[d] = 0; e_mc[d] = 0;
            e_lk[d] = 0; e_lch[d] = 0; e_ptr[d] = 0;
        end
        acc0 = '0;
    endtask

    task automatic reset_check(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d m_valid", tag, d), 32'(mv[d]), 32'd0);
            chk($sformatf("%s d%0d busy", tag, d), 32'(bz[d]), 32'd0);
            chk($sformatf("%s d%0d s_ready", tag, d), 32'(rdy[d]), 32'd0);
            chk($sformatf("%s d%0d m_chan", tag, d), 32'(mc[d]), 32'd0);
        end
    endtask

    // Compare one instance against the reference, then advance the reference
    // by the transfer rules for the upcoming clock edge.
    task automatic model_step(input int d);
        bit             room;
        bit             found;
        int             g;
        int             c;
        int             start;
        logic [NCH-1:0] er;
        room  = !e_mv[d] || m_ready;
        found = 0;
        g     = 0;
        start = (d == 0) ? e_ptr[d] : 0;
        if (e_lk[d]) begin
            found = 1;
            g     = e_lch[d];
        end else begin
            for (int k = 0; k < NCH; k++) begin
                c = (start + k) % NCH;
                if (!found && s_valid[c]) begin
                    found = 1;
                    g     = c;
                end
            end
        end
        er = (found && room) ? (NCH'(1) << g) : '0;

        chk($sformatf("d%0d s_ready", d), 32'(rdy[d]), 32'(er));
        chk($sformatf("d%0d m_valid", d), 32'(mv[d]), 32'(e_mv[d]));
        chk($sformatf("d%0d busy", d), 32'(bz[d]), 32'(e_lk[d]));
        if (e_mv[d]) begin
            chk($sformatf("d%0d m_data", d), 32'(md[d]), 32'(e_md[d]));
            chk($sformatf("d%0d m_last", d), 32'(ml[d]), 32'(e_ml[d]));
            chk($sformatf("d%0d m_chan", d), 32'(mc[d]), 32'(e_mc[d]));
        end

        if (d == 0) acc0 = er & s_valid;

        if (found && room && s_valid[g]) begin
            e_mv[d] = 1;
            e_md[d] = s_data[g*DW +: DW];
            e_ml[d] = s_last[g];
            e_mc[d] = g;
            if (s_last[g]) begin
                e_lk[d] = 0;
                if (d == 0) e_ptr[d] = (g + 1) % NCH;
            end else begin
                e_lk[d]  = 1;
                e_lch[d] = g;
            end
        end else if (m_ready) begin
            e_mv[d] = 0;
        end
    endtask

    task automatic drive(input int pvalid, input int maxlen, input int mready,
                         input int drop, input logic [NCH-1:0] mask);
        for (int i = 0; i < NCH; i++) begin
            if (acc0[i]) begin
                pdat[i] = pdat[i] + 1'b1;
                prem[i] = prem[i] - 1;
                if (prem[i] == 0) pv[i] = 0;
            end
            if (!pv[i] && mask[i] && int'($urandom_range(0, 99)) < pvalid) begin
                pv[i]   = 1;
                prem[i] = (maxlen <= 1) ? 1 : int'($urandom_range(1, maxlen));
            end
            s_valid[i] = pv[i] && !(int'($urandom_range(0, 99)) < drop);
            s_last[i]  = pv[i] ? (prem[i] == 1) : 1'($urandom);
            s_data[i*DW +: DW] = pv[i] ? pdat[i] : DW'($urandom);
        end
        m_ready = int'($urandom_range(0, 99)) < mready;
        acc0    = '0;
    endtask

    task automatic run(input int n, input int pvalid, input int maxlen, input int mready,
                       input int drop, input logic [NCH-1:0] mask);
        repeat (n) begin
            drive(pvalid, maxlen, mready, drop, mask);
            #3;
            model_step(0);
            model_step(1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mid_reset();
        drive(100, 3, 100, 0, '1);
        #2;
        rst_n = 1'b0;
        #1;
        reset_check("midrst");
        @(posedge clk);
        #1;
        reset_check("midrst_hold");
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < NCH; i++) begin
            pv[i]   = 0;
            pdat[i] = DW'(i << 4);
            prem[i] = 0;
        end
        rst_n   = 1'b0;
        s_valid = '1;
        s_last  = '0;
        s_data  = '0;
        m_ready = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset_check("reset");
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        s_valid = '0;
        model_reset();

        run(300, 60, 3, 75, 10, 4'b1111);   // general mix
        run(40, 100, 1, 100, 0, 4'b1111);   // all channels single-beat, full rate
        run(60, 100, 4, 100, 0, 4'b1111);   // multi-beat packets back to back
        run(80, 90, 3, 20, 0, 4'b1111);     // heavy sink backpressure
        run(100, 80, 5, 90, 50, 4'b1111);   // locked channels stalling
        mid_reset();
        run(30, 100, 1, 100, 0, 4'b0101);   // ch0 and ch2 only
        run(20, 100, 1, 100, 0, 4'b0100);   // ch0 goes quiet
        run(600, 50, 4, 70, 20, 4'b1111);   // long random soak

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
